ring_johnson_cnt: RTL



---
 rtl/ring_cnt_pkg.sv | 27 ++
 rtl/ring_state_chk.sv | 38 +++
 rtl/ring_johnson_cnt.sv | 92 +++++++++
 3 files changed

// File: rtl/ring_cnt_pkg.sv
// ============================================================================
// Module      : ring_cnt_pkg
// Description : Shared encodings and seed helper for the ring/Johnson counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_cnt_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam int MAX_WIDTH = 32;

   // Sequence start value for a mode, returned at full width; callers
   // size-cast to their own width. Ring starts one-hot at bit 0, Johnson
   // starts all zeros.
   function automatic logic [MAX_WIDTH-1:0] seed_value(input logic mode);
      return (mode == MODE_JOHNSON) ? '0 : MAX_WIDTH'(1);
   endfunction

endpackage : ring_cnt_pkg

`default_nettype wire

// File: rtl/ring_state_chk.sv
// ============================================================================
// Module      : ring_state_chk
// Description : Combinational legality check of a ring/Johnson counter state.
//               Ring: exactly one bit set. Johnson: at most one boundary
//               between adjacent bits (0^a 1^b or 1^a 0^b).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_state_chk
   import ring_cnt_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] state,
   input  logic             mode,
   output logic             legal
);

   logic [5:0] ones;
   logic [5:0] trans;

   // Count set bits and adjacent-bit transitions, then judge per mode.
   always_comb begin
      ones  = '0;
      trans = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + {5'd0, state[i]};
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
         trans = trans + {5'd0, state[i] ^ state[i+1]};
      end
      legal = (mode == MODE_JOHNSON) ? (trans <= 6'd1) : (ones == 6'd1);
   end

endmodule : ring_state_chk

`default_nettype wire

// File: rtl/ring_johnson_cnt.sv
// ============================================================================
// Module      : ring_johnson_cnt
// Description : Parametrised ring / Johnson counter with direction, enable,
//               parallel load, terminal-count pulse and illegal-state flag.
//               Optional macro RING_SELF_CORRECT_EN: an illegal state is
//               replaced by the seed on the next edge with a one-cycle err
//               pulse; otherwise err is sticky until the next load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_johnson_cnt
   import ring_cnt_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] d_out,
   output logic             tc,
   output logic             err
);

   logic             mode_q;
   logic             mode_chg;
   logic             legal;
   logic             illegal;
   logic [WIDTH-1:0] seed_new;
   logic [WIDTH-1:0] seed_cur;
   logic [WIDTH-1:0] step_val;

   assign mode_chg = (mode != mode_q);
   assign seed_new = WIDTH'(seed_value(mode));
   assign seed_cur = WIDTH'(seed_value(mode_q));
   assign illegal  = ~legal;

   ring_state_chk #(.WIDTH(WIDTH)) u_chk (
      .state (d_out),
      .mode  (mode_q),
      .legal (legal)
   );

   // One step of the active sequence; Johnson inverts the bit wrapping round.
   always_comb begin
      step_val = d_out;
      case ({mode_q, dir})
         {MODE_RING,    DIR_LEFT}  : step_val = {d_out[WIDTH-2:0], d_out[WIDTH-1]};
         {MODE_RING,    DIR_RIGHT} : step_val = {d_out[0], d_out[WIDTH-1:1]};
         {MODE_JOHNSON, DIR_LEFT}  : step_val = {d_out[WIDTH-2:0], ~d_out[WIDTH-1]};
         default                   : step_val = {~d_out[0], d_out[WIDTH-1:1]};
      endcase
   end

   // State register: load > reseed on mode change > correction > step > hold.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         d_out  <= WIDTH'(1);
         tc     <= 1'b0;
         err    <= 1'b0;
         mode_q <= MODE_RING;
      end else begin
         mode_q <= mode;
         tc     <= 1'b0;
`ifdef RING_SELF_CORRECT_EN
         err    <= illegal & ~load;
`else
         err    <= err | illegal;
`endif
         if (load) begin
            d_out <= load_val;
            err   <= 1'b0;
         end else if (mode_chg) begin
            d_out <= seed_new;
`ifdef RING_SELF_CORRECT_EN
         end else if (illegal) begin
            d_out <= seed_cur;
`endif
         end else if (en) begin
            d_out <= step_val;
            tc    <= (step_val == seed_cur);
         end
      end
   end

endmodule : ring_johnson_cnt

`default_nettype wire
